// File: rtl/max_exp_tree_acc.sv
// max_exp_tree_acc: pipelined masked max-reduction tree feeding a per-group
// running-maximum accumulator, with a valid/ready result register.
module max_exp_tree_acc #(
    parameter int DATA_WIDTH = 6,
    parameter int NUM_IN     = 8,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] v_exp [NUM_IN],
    input  logic [NUM_IN-1:0]     v_mask,
    input  logic [DATA_WIDTH-1:0] acc_exp,
    input  logic                  acc_en,
    input  logic [CNT_WIDTH-1:0]  grp_len,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_exp
);
    localparam int T = $clog2(NUM_IN);
    localparam int N = NUM_IN - 1;
    typedef logic [DATA_WIDTH-1:0] exp_t;

    function automatic exp_t mx(input exp_t a, input exp_t b);
        return a > b ? a : b;
    endfunction

    logic                 pipe_en, accept, first, last, acc_last;
    logic [CNT_WIDTH-1:0] beat_cnt, len_q, eff_len;
    logic [T-1:0]         v_q, f_q, l_q;
    exp_t                 node [N];
    exp_t                 all_n [2*NUM_IN-1];
    exp_t                 a_q [T];
    exp_t                 run_max;

    assign pipe_en  = !out_valid || out_ready;
    assign in_ready = pipe_en;
    assign accept   = in_valid && pipe_en;
    assign first    = beat_cnt == '0;
    assign eff_len  = !first ? len_q : (grp_len == '0 ? CNT_WIDTH'(1) : grp_len);
    assign last     = beat_cnt == eff_len - CNT_WIDTH'(1);

    // Heap layout: registered internal nodes first, masked input lanes as leaves.
    always_comb begin
        for (int j = 0; j < N; j++) all_n[j] = node[j];
        for (int i = 0; i < NUM_IN; i++) all_n[N+i] = v_mask[i] ? v_exp[i] : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt  <= '0;
            len_q     <= '0;
            v_q       <= '0;
            f_q       <= '0;
            l_q       <= '0;
            acc_last  <= 1'b0;
            run_max   <= '0;
            out_valid <= 1'b0;
            out_exp   <= '0;
            for (int j = 0; j < N; j++) node[j] <= '0;
            for (int k = 0; k < T; k++) a_q[k] <= '0;
        end else if (pipe_en) begin
            if (accept) begin
                beat_cnt <= last ? '0 : beat_cnt + CNT_WIDTH'(1);
                if (first) len_q <= eff_len;
            end
            for (int j = 0; j < N; j++) node[j] <= mx(all_n[2*j+1], all_n[2*j+2]);
            for (int k = T - 1; k > 0; k--) begin
                v_q[k] <= v_q[k-1];
                f_q[k] <= f_q[k-1];
                l_q[k] <= l_q[k-1];
                a_q[k] <= a_q[k-1];
            end
            v_q[0] <= accept;
            f_q[0] <= first;
            l_q[0] <= last;
            a_q[0] <= (first && acc_en) ? acc_exp : '0;
            // Root node[0] lines up with the last flag stage.
            acc_last <= v_q[T-1] && l_q[T-1];
            if (v_q[T-1]) run_max <= f_q[T-1] ? mx(node[0], a_q[T-1]) : mx(run_max, node[0]);
            out_valid <= acc_last;
            if (acc_last) out_exp <= run_max;
        end
    end
endmodule

// File: tb/tb_max_exp_tree_acc.sv
// tb_max_exp_tree_acc: directed vectors with a scoreboard queue checked by an
// independent output monitor.
module tb_max_exp_tree_acc;
    logic       clk = 0, reset = 1, in_valid = 0, acc_en = 0, out_ready = 1;
    logic       in_ready, out_valid;
    logic [5:0] v_exp [8];
    logic [7:0] v_mask = '0;
    logic [5:0] acc_exp = '0, out_exp;
    logic [3:0] grp_len = 4'd1;
    int         total = 0, bad = 0, delivered = 0;
    logic [5:0] exp_q [$];

    max_exp_tree_acc #(.DATA_WIDTH(6), .NUM_IN(8), .CNT_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .v_exp(v_exp), .v_mask(v_mask), .acc_exp(acc_exp), .acc_en(acc_en),
        .grp_len(grp_len), .out_valid(out_valid), .out_ready(out_ready), .out_exp(out_exp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic send(input logic [5:0] e [8], input logic [7:0] m, input logic [5:0] ae,
                        input logic aen, input logic [3:0] gl);
        logic rdy;
        rdy = 1'b0;
        v_exp = e; v_mask = m; acc_exp = ae; acc_en = aen; grp_len = gl; in_valid = 1'b1;
        for (int n = 0; n < 50 && !rdy; n++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
        end
        if (!rdy) begin
            total++; bad++;
            $display("FAIL send_timeout: in_ready stayed 0 for 50 cycles");
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(negedge clk);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_output: got %0d expected none", out_exp);
            end else begin
                delivered++;
                check("out_exp", out_exp, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [5:0] e [8];
        int n;
        v_exp = '{default: 0};
        #2;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_exp", out_exp, 0);
        @(posedge clk); #1 reset = 0;

        // single-beat group, latency
        e = '{3, 9, 1, 0, 7, 2, 5, 4};
        exp_q.push_back(9);
        send(e, 8'hFF, 6'd6, 1'b1, 4'd1);
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        check("latency", n, 4);
        idle(2);

        // acc dominance and masking, grp_len 0 means 1
        e = '{4, 63, 10, 2, 0, 9, 1, 3};
        exp_q.push_back(12);
        send(e, 8'hFD, 6'd12, 1'b1, 4'd0);
        exp_q.push_back(10);
        send(e, 8'hFD, 6'd12, 1'b0, 4'd0);
        idle(6);

        // 3-beat group with bubbles; beat 2 fields must be ignored
        e = '{5, 1, 0, 2, 3, 4, 0, 1};
        send(e, 8'hFF, 6'd40, 1'b0, 4'd3);
        idle(3);
        e = '{0, 20, 3, 7, 1, 2, 9, 6};
        send(e, 8'hFF, 6'd50, 1'b1, 4'd1);
        idle(6);
        check("no_early_out", out_valid, 0);
        e = '{11, 0, 3, 7, 1, 2, 9, 6};
        exp_q.push_back(20);
        send(e, 8'hFF, 6'd0, 1'b0, 4'd3);
        idle(8);

        // back-pressure
        out_ready = 1'b0;
        exp_q.push_back(4); exp_q.push_back(8); exp_q.push_back(15);
        e = '{1, 4, 0, 2, 3, 0, 0, 1};
        send(e, 8'hFF, 6'd0, 1'b0, 4'd1);
        e = '{8, 4, 0, 2, 3, 0, 0, 1};
        send(e, 8'hFF, 6'd0, 1'b0, 4'd1);
        e = '{1, 4, 0, 2, 15, 0, 0, 1};
        send(e, 8'hFF, 6'd0, 1'b0, 4'd1);
        idle(3);
        for (int k = 0; k < 5; k++) begin
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            check("stall_hold", out_exp, 4);
            idle(1);
        end
        out_ready = 1'b1;
        idle(6);

        // reset mid-group with a held result pending
        out_ready = 1'b0;
        e = '{33, 4, 0, 2, 3, 0, 0, 1};
        send(e, 8'hFF, 6'd0, 1'b0, 4'd1);
        e = '{50, 4, 0, 2, 3, 0, 0, 1};
        send(e, 8'hFF, 6'd0, 1'b0, 4'd4);
        send(e, 8'hFF, 6'd0, 1'b0, 4'd4);
        n = 0;
        while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
        check("pre_reset_valid", out_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("async_reset_valid", out_valid, 0);
        check("async_reset_exp", out_exp, 0);
        check("async_reset_in_ready", in_ready, 1);
        @(posedge clk); #1;
        check("reset_held_in_ready", in_ready, 1);
        reset = 1'b0;
        out_ready = 1'b1;
        e = '{1, 7, 0, 2, 3, 0, 0, 1};
        exp_q.push_back(7);
        send(e, 8'hFF, 6'd0, 1'b0, 4'd1);
        idle(10);

        check("queue_empty", exp_q.size(), 0);
        check("delivered", delivered, 8);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/max_exp_tree_acc.md
MAX_EXP_TREE_ACC -- requirements
Module: max_exp_tree_acc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 6, exponent width in bits (unsigned).
REQ-002 SHALL have parameter NUM_IN, default 8, lanes per beat; power of two, 2..32.
REQ-003 SHALL have parameter CNT_WIDTH, default 4, width of the group-length field.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  beat present.
REQ-007 SHALL have port in_ready  output  1  beat accepted when in_valid&in_ready at a rising edge.
REQ-008 SHALL have port v_exp  input  DATA_WIDTH x NUM_IN (unpacked array)  lane exponents.
REQ-009 SHALL have port v_mask  input  NUM_IN  lane enable; 0 = lane contributes 0.
REQ-010 SHALL have port acc_exp  input  DATA_WIDTH  accumulator exponent joined into the group max.
REQ-011 SHALL have port acc_en  input  1  1 = include acc_exp; 0 = acc contributes 0.
REQ-012 SHALL have port grp_len  input  CNT_WIDTH  beats per group; 0 treated as 1.
REQ-013 SHALL have port out_valid  output  1  group result present.
REQ-014 SHALL have port out_ready  input  1  consumer accepts result.
REQ-015 SHALL have port out_exp  output  DATA_WIDTH  max exponent of the completed group.

Function
REQ-016 SHALL compare unsigned; max of equal values is that value; no width growth.
REQ-017 SHALL reduce the NUM_IN masked lanes with a binary comparator tree of T = log2(NUM_IN) levels, each level registered.
REQ-018 SHALL follow the tree with one accumulate stage holding run_max, then the out_exp/out_valid register.
REQ-019 SHALL define pipe_en = !out_valid | out_ready; every pipeline register, flag and the beat counter advance only when pipe_en = 1.
REQ-020 SHALL drive in_ready = pipe_en (combinational; no dependence on in_valid).
REQ-021 SHALL keep beat_cnt and len_q on the input side; on an accepted beat with beat_cnt = 0, len_q is loaded from grp_len (0 -> 1) and acc_exp/acc_en are sampled.
REQ-022 SHALL tag each accepted beat first = (beat_cnt = 0) and last = (beat_cnt = effective length - 1), using grp_len directly when beat_cnt = 0; beat_cnt increments, wrapping to 0 after a last beat.
REQ-023 SHALL carry valid, first, last and the sampled acc value (acc_en ? acc_exp : 0) alongside the data through every tree stage.
REQ-024 SHALL, in the accumulate stage: on a first beat load run_max = max(tree_out, acc value), otherwise run_max = max(run_max, tree_out); a beat that is both first and last does the load.
REQ-025 SHALL, on a last beat, set out_valid = 1 and out_exp = the updated run_max; non-last beats leave out_valid unchanged (0 or cleared by handshake).
REQ-026 SHALL clear out_valid when out_valid&out_ready and no new last beat arrives in the same cycle; a simultaneous new result overwrites the accepted one with out_valid held at 1.
REQ-027 SHALL produce out_valid T+1 rising edges after the edge accepting the last beat of a group, absent stalls; throughput one beat per cycle.
REQ-028 SHALL hold out_exp stable while out_valid&!out_ready.
REQ-029 SHALL ignore grp_len, acc_exp and acc_en on beats with beat_cnt != 0.
REQ-030 SHALL ignore in_valid = 0 cycles: no flag propagates, beat_cnt holds, run_max holds across bubbles.

Reset
REQ-031 SHALL, on reset assertion, immediately clear out_valid, out_exp, run_max, beat_cnt, len_q and all stage valid flags to 0, regardless of clk.
REQ-032 SHALL discard any partial group in flight at reset; the first beat accepted after reset deassertion is a first beat.
REQ-033 SHALL hold in_ready = 1 during and after reset (out_valid = 0).

Verification (defaults: NUM_IN=8, T=3, latency 4)
REQ-034 SHALL cover single-beat group: grp_len=1, v_exp={3,9,1,0,7,2,5,4}, all masked in, acc_en=1, acc_exp=6 -> out_exp=9, out_valid 4 edges after acceptance.
REQ-035 SHALL cover acc dominance and masking: grp_len=0, lane 1 masked off (v_exp[1]=63), others <=10, acc_exp=12, acc_en=1 -> out_exp=12; same with acc_en=0 -> out_exp=10.
REQ-036 SHALL cover 3-beat group with bubbles: grp_len=3, beat maxima 5, 20, 11 with idle cycles between, acc_en=0 -> exactly one out_valid pulse, out_exp=20; grp_len changed to 1 on beat 2 has no effect.
REQ-037 SHALL cover back-pressure: back-to-back single-beat groups maxima 4, 8, 15 with out_ready=0 for 5 cycles -> in_ready drops once out_valid=1, out_exp holds 4, then 4, 8, 15 delivered in order, none lost or duplicated.
REQ-038 SHALL cover reset mid-group: grp_len=4, two beats accepted, reset pulsed between edges -> out_valid=0 immediately, next group grp_len=1 max 7 -> out_exp=7, no stale contribution.
